// File: rtl/ps2_pkg.sv
// Shared constants and FSM state type for the PS/2 Set-2 scan-code decoder.
package ps2_pkg;

  localparam logic [7:0] PS2_EXT   = 8'hE0;
  localparam logic [7:0] PS2_BRK   = 8'hF0;
  localparam logic [7:0] SC_LSHIFT = 8'h12;
  localparam logic [7:0] SC_RSHIFT = 8'h59;

  typedef enum logic [1:0] {
    S_BASE   = 2'd0,
    S_EXT    = 2'd1,
    S_BRK    = 2'd2,
    S_EXTBRK = 2'd3
  } ps2_state_e;

  // Keyboard status/ack bytes that never start a key sequence.
  function automatic logic ps2_is_ignored(input logic [7:0] b);
    logic r;
    case (b)
      8'hAA, 8'hFA, 8'hFE, 8'h00, 8'hFF, 8'hE1: r = 1'b1;
      default:                                  r = 1'b0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/ps2_ascii_rom.sv
// Set-2 make code to ASCII: letters (shift selects case), digits, space, enter.
module ps2_ascii_rom (
  input  logic [7:0] i_code,
  input  logic       i_shift,
  output logic [7:0] o_ascii
);

  logic [7:0] w_base;
  logic       w_letter;

  always_comb begin
    w_base   = 8'h00;
    w_letter = 1'b1;
    case (i_code)
      8'h1C: w_base = "a";  8'h32: w_base = "b";  8'h21: w_base = "c";
      8'h23: w_base = "d";  8'h24: w_base = "e";  8'h2B: w_base = "f";
      8'h34: w_base = "g";  8'h33: w_base = "h";  8'h43: w_base = "i";
      8'h3B: w_base = "j";  8'h42: w_base = "k";  8'h4B: w_base = "l";
      8'h3A: w_base = "m";  8'h31: w_base = "n";  8'h44: w_base = "o";
      8'h4D: w_base = "p";  8'h15: w_base = "q";  8'h2D: w_base = "r";
      8'h1B: w_base = "s";  8'h2C: w_base = "t";  8'h3C: w_base = "u";
      8'h2A: w_base = "v";  8'h1D: w_base = "w";  8'h22: w_base = "x";
      8'h35: w_base = "y";  8'h1A: w_base = "z";
      default: begin
        w_letter = 1'b0;
        case (i_code)
          8'h45: w_base = "0";  8'h16: w_base = "1";  8'h1E: w_base = "2";
          8'h26: w_base = "3";  8'h25: w_base = "4";  8'h2E: w_base = "5";
          8'h36: w_base = "6";  8'h3D: w_base = "7";  8'h3E: w_base = "8";
          8'h46: w_base = "9";
          8'h29: w_base = 8'h20;
          8'h5A: w_base = 8'h0D;
          default: w_base = 8'h00;
        endcase
      end
    endcase
    o_ascii = (w_letter && i_shift) ? (w_base - 8'h20) : w_base;
  end

endmodule

// File: rtl/ps2_scan_decoder.sv
// Pops scan-code bytes from the PS/2 FIFO and decodes Set-2 make/break/E0
// sequences into single registered key events with held-key and shift tracking.
module ps2_scan_decoder
  import ps2_pkg::*;
#(
  parameter bit REPEAT_EN = 1'b0,
  parameter int CNT_W     = 8
) (
  input  logic             i_clk,
  input  logic             i_clr,
  input  logic             i_ready,
  input  logic [7:0]       i_data,
  output logic             o_nextdata_n,
  output logic             o_key_valid,
  output logic [7:0]       o_key_code,
  output logic             o_key_ext,
  output logic             o_key_break,
  output logic [7:0]       o_key_ascii,
  output logic             o_key_down,
  output logic             o_shift_down,
  output logic [CNT_W-1:0] o_press_count,
  output logic             o_proto_err
);

  ps2_state_e       r_state, w_state_nxt;
  logic             r_vld;
  logic [7:0]       r_byte;
  logic             r_key_valid, r_key_ext, r_key_break, r_key_down, r_proto_err;
  logic [7:0]       r_key_code, r_key_ascii;
  logic [CNT_W-1:0] r_press_count;
  logic [8:0]       r_held;
  logic             r_lshift, r_rshift;

  logic       w_pop, w_evt, w_evt_ext, w_evt_brk, w_perr;
  logic       w_match, w_repeat, w_emit, w_new_press;
  logic [7:0] w_rom_ascii;

  assign w_pop        = i_ready & ~i_clr;
  assign o_nextdata_n = ~w_pop;

  // Byte stage: every presented byte is taken, decode runs one cycle later.
  always_ff @(posedge i_clk or posedge i_clr) begin
    if (i_clr) begin
      r_vld  <= 1'b0;
      r_byte <= 8'h00;
    end else begin
      r_vld <= w_pop;
      if (w_pop) r_byte <= i_data;
    end
  end

  always_ff @(posedge i_clk or posedge i_clr) begin
    if (i_clr) r_state <= S_BASE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_evt       = 1'b0;
    w_evt_ext   = 1'b0;
    w_evt_brk   = 1'b0;
    w_perr      = 1'b0;
    if (r_vld) begin
      case (r_state)
        S_BASE: begin
          if (r_byte == PS2_EXT)            w_state_nxt = S_EXT;
          else if (r_byte == PS2_BRK)       w_state_nxt = S_BRK;
          else if (!ps2_is_ignored(r_byte)) w_evt = 1'b1;
        end
        S_EXT: begin
          if (r_byte == PS2_BRK)      w_state_nxt = S_EXTBRK;
          else if (r_byte == PS2_EXT) w_perr = 1'b1;
          else begin
            w_evt       = 1'b1;
            w_evt_ext   = 1'b1;
            w_state_nxt = S_BASE;
          end
        end
        S_BRK, S_EXTBRK: begin
          w_state_nxt = S_BASE;
          if (r_byte == PS2_EXT || r_byte == PS2_BRK) w_perr = 1'b1;
          else begin
            w_evt     = 1'b1;
            w_evt_brk = 1'b1;
            w_evt_ext = (r_state == S_EXTBRK);
          end
        end
        default: w_state_nxt = S_BASE;
      endcase
    end
  end

  assign w_match     = r_key_down && ({w_evt_ext, r_byte} == r_held);
  assign w_repeat    = w_evt & ~w_evt_brk & w_match;
  assign w_emit      = w_evt & ~(w_repeat & ~REPEAT_EN);
  assign w_new_press = w_evt & ~w_evt_brk & ~w_match;

  // Shift state before this byte selects the case of the letter.
  ps2_ascii_rom u_rom (
    .i_code  (r_byte),
    .i_shift (o_shift_down),
    .o_ascii (w_rom_ascii)
  );

  always_ff @(posedge i_clk or posedge i_clr) begin
    if (i_clr) begin
      r_key_valid   <= 1'b0;
      r_proto_err   <= 1'b0;
      r_key_code    <= 8'h00;
      r_key_ext     <= 1'b0;
      r_key_break   <= 1'b0;
      r_key_ascii   <= 8'h00;
      r_key_down    <= 1'b0;
      r_held        <= 9'h000;
      r_press_count <= '0;
      r_lshift      <= 1'b0;
      r_rshift      <= 1'b0;
    end else begin
      r_key_valid <= w_emit;
      r_proto_err <= w_perr;
      if (w_emit) begin
        r_key_code  <= r_byte;
        r_key_ext   <= w_evt_ext;
        r_key_break <= w_evt_brk;
        r_key_ascii <= (w_evt_ext | w_evt_brk) ? 8'h00 : w_rom_ascii;
      end
      if (w_new_press) begin
        r_press_count <= r_press_count + 1'b1;
        r_held        <= {w_evt_ext, r_byte};
        r_key_down    <= 1'b1;
      end else if (w_evt && w_evt_brk && w_match) begin
        r_key_down <= 1'b0;
      end
      if (w_evt && !w_evt_ext && r_byte == SC_LSHIFT) r_lshift <= ~w_evt_brk;
      if (w_evt && !w_evt_ext && r_byte == SC_RSHIFT) r_rshift <= ~w_evt_brk;
    end
  end

  assign o_key_valid   = r_key_valid;
  assign o_proto_err   = r_proto_err;
  assign o_key_code    = r_key_code;
  assign o_key_ext     = r_key_ext;
  assign o_key_break   = r_key_break;
  assign o_key_ascii   = r_key_ascii;
  assign o_key_down    = r_key_down;
  assign o_press_count = r_press_count;
  assign o_shift_down  = r_lshift | r_rshift;

endmodule

// File: tb/tb_ps2_scan_decoder.sv
// Drives byte streams into two decoder instances (repeat off/8-bit count,
// repeat on/3-bit count) and compares every cycle against a prefix-queue model.
module tb_ps2_scan_decoder;

  typedef logic [30:0] vec_t;

  logic       clk = 1'b0;
  logic       clr, ready;
  logic [7:0] data;

  logic       nd0, v0, e0, b0, kd0, sd0, pe0;
  logic [7:0] c0, a0, pc0;
  logic       nd1, v1, e1, b1, kd1, sd1, pe1;
  logic [7:0] c1, a1;
  logic [2:0] pc1;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  ps2_scan_decoder #(.REPEAT_EN(1'b0), .CNT_W(8)) dut0 (
    .i_clk(clk), .i_clr(clr), .i_ready(ready), .i_data(data),
    .o_nextdata_n(nd0), .o_key_valid(v0), .o_key_code(c0), .o_key_ext(e0),
    .o_key_break(b0), .o_key_ascii(a0), .o_key_down(kd0), .o_shift_down(sd0),
    .o_press_count(pc0), .o_proto_err(pe0));

  ps2_scan_decoder #(.REPEAT_EN(1'b1), .CNT_W(3)) dut1 (
    .i_clk(clk), .i_clr(clr), .i_ready(ready), .i_data(data),
    .o_nextdata_n(nd1), .o_key_valid(v1), .o_key_code(c1), .o_key_ext(e1),
    .o_key_break(b1), .o_key_ascii(a1), .o_key_down(kd1), .o_shift_down(sd1),
    .o_press_count(pc1), .o_proto_err(pe1));

  // Reference model: pending prefixes plus held key, one set per instance.
  logic       m_rep[2]  = '{1'b0, 1'b1};
  logic [7:0] m_mask[2] = '{8'hFF, 8'h07};
  logic       m_pext[2], m_pbrk[2], m_valid[2], m_perr[2], m_ext[2], m_brk[2];
  logic       m_down[2], m_lsh[2], m_rsh[2];
  logic [7:0] m_code[2], m_asc[2], m_cnt[2];
  logic [8:0] m_held[2];

  logic [7:0] sq[$];
  vec_t obs0[$], obs1[$], exp0[$], exp1[$];

  function automatic logic [7:0] ref_ascii(input logic [7:0] c, input logic sh);
    logic [7:0] lc[26] = '{8'h1C,8'h32,8'h21,8'h23,8'h24,8'h2B,8'h34,8'h33,8'h43,
                           8'h3B,8'h42,8'h4B,8'h3A,8'h31,8'h44,8'h4D,8'h15,8'h2D,
                           8'h1B,8'h2C,8'h3C,8'h2A,8'h1D,8'h22,8'h35,8'h1A};
    logic [7:0] dc[10] = '{8'h45,8'h16,8'h1E,8'h26,8'h25,8'h2E,8'h36,8'h3D,8'h3E,8'h46};
    for (int i = 0; i < 26; i++) if (c == lc[i]) return (sh ? 8'd65 : 8'd97) + 8'(i);
    for (int i = 0; i < 10; i++) if (c == dc[i]) return 8'd48 + 8'(i);
    if (c == 8'h29) return 8'h20;
    if (c == 8'h5A) return 8'h0D;
    return 8'h00;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_pext[k] = 0; m_pbrk[k] = 0; m_valid[k] = 0; m_perr[k] = 0; m_ext[k] = 0;
      m_brk[k] = 0; m_down[k] = 0; m_lsh[k] = 0; m_rsh[k] = 0; m_code[k] = 0;
      m_asc[k] = 0; m_cnt[k] = 0; m_held[k] = 0;
    end
  endtask

  task automatic model_byte(input int k, input logic [7:0] b);
    logic x, br;
    logic [7:0] asc;
    m_valid[k] = 0; m_perr[k] = 0;
    if (b == 8'hE0) begin
      if (m_pbrk[k]) begin m_perr[k] = 1; m_pext[k] = 0; m_pbrk[k] = 0; end
      else if (m_pext[k]) m_perr[k] = 1;
      else m_pext[k] = 1;
    end else if (b == 8'hF0) begin
      if (m_pbrk[k]) begin m_perr[k] = 1; m_pext[k] = 0; m_pbrk[k] = 0; end
      else m_pbrk[k] = 1;
    end else if (!m_pext[k] && !m_pbrk[k] && b inside {8'hAA,8'hFA,8'hFE,8'h00,8'hFF,8'hE1}) begin
    end else begin
      x = m_pext[k]; br = m_pbrk[k];
      m_pext[k] = 0; m_pbrk[k] = 0;
      asc = (x || br) ? 8'h00 : ref_ascii(b, m_lsh[k] | m_rsh[k]);
      if (br) begin
        m_valid[k] = 1;
        if (m_down[k] && m_held[k] == {x, b}) m_down[k] = 0;
      end else if (m_down[k] && m_held[k] == {x, b}) begin
        m_valid[k] = m_rep[k];
      end else begin
        m_valid[k] = 1;
        m_cnt[k] = (m_cnt[k] + 8'd1) & m_mask[k];
        m_held[k] = {x, b};
        m_down[k] = 1;
      end
      if (m_valid[k]) begin
        m_code[k] = b; m_ext[k] = x; m_brk[k] = br; m_asc[k] = asc;
      end
      if (!x && b == 8'h12) m_lsh[k] = ~br;
      if (!x && b == 8'h59) m_rsh[k] = ~br;
    end
  endtask

  // Feeds sq with random idle gaps (0..max_gap), recording DUT and model
  // output vectors each cycle. Entered and left on a falling edge.
  task automatic play(input int max_gap);
    int idx = 0, gap;
    logic pend_v = 0, cur_v;
    logic [7:0] pend = 0;
    logic s0, s1;
    obs0.delete(); obs1.delete(); exp0.delete(); exp1.delete();
    gap = (max_gap > 0) ? $urandom_range(max_gap, 0) : 0;
    while (idx < sq.size() || pend_v) begin
      if (idx < sq.size() && gap == 0) begin
        ready = 1; data = sq[idx]; idx++;
        gap = (max_gap > 0) ? $urandom_range(max_gap, 0) : 0;
      end else begin
        ready = 0; data = 8'($urandom);
        if (gap > 0) gap--;
      end
      cur_v = ready;
      #1; s0 = nd0; s1 = nd1;
      @(posedge clk);
      for (int k = 0; k < 2; k++)
        if (pend_v) model_byte(k, pend);
        else begin m_valid[k] = 0; m_perr[k] = 0; end
      pend_v = cur_v; pend = data;
      @(negedge clk);
      obs0.push_back({s0, v0, c0, e0, b0, a0, pe0, kd0, sd0, pc0});
      obs1.push_back({s1, v1, c1, e1, b1, a1, pe1, kd1, sd1, 5'b0, pc1});
      for (int k = 0; k < 2; k++) begin
        vec_t ev = {~cur_v, m_valid[k], m_code[k], m_ext[k], m_brk[k], m_asc[k],
                    m_perr[k], m_down[k], m_lsh[k] | m_rsh[k], m_cnt[k]};
        if (k == 0) exp0.push_back(ev); else exp1.push_back(ev);
      end
    end
    ready = 0;
  endtask

  task automatic do_reset();
    clr = 1; ready = 0;
    repeat (2) @(negedge clk);
    clr = 0;
    model_reset();
  endtask

  task automatic test_reset();
    clr = 1; ready = 1; data = 8'h1C;
    #1;
    checks++;
    if ({nd0, nd1} !== 2'b11) begin
      failures++; $display("FAIL reset_nextdata got=%b required=11", {nd0, nd1});
    end
    @(posedge clk); @(negedge clk);
    checks++;
    if ({v0, c0, e0, b0, a0, kd0, sd0, pc0, pe0} !== 36'h0) begin
      failures++; $display("FAIL reset_outs0 got=%h required=0", {v0, c0, e0, b0, a0, kd0, sd0, pc0, pe0});
    end
    checks++;
    if ({v1, c1, e1, b1, a1, kd1, sd1, pc1, pe1} !== 31'h0) begin
      failures++; $display("FAIL reset_outs1 got=%h required=0", {v1, c1, e1, b1, a1, kd1, sd1, pc1, pe1});
    end
    ready = 0; clr = 0;
    model_reset();
    @(negedge clk);
  endtask

  task automatic test_basic();
    vec_t ev[$];
    do_reset();
    sq = '{8'h1C, 8'hF0, 8'h1C};
    play(2);
    foreach (obs0[i]) begin
      checks += 2;
      if (obs0[i] !== exp0[i]) begin failures++; $display("FAIL basic dut0 cyc=%0d got=%h exp=%h", i, obs0[i], exp0[i]); end
      if (obs1[i] !== exp1[i]) begin failures++; $display("FAIL basic dut1 cyc=%0d got=%h exp=%h", i, obs1[i], exp1[i]); end
      if (obs0[i][29]) ev.push_back(obs0[i]);
    end
    checks++;
    if (ev.size() != 2 || ev[0][28:21] !== 8'h1C || ev[0][18:11] !== 8'h61 || ev[0][9] !== 1'b1
        || ev[1][19] !== 1'b1 || ev[1][18:11] !== 8'h00 || ev[1][9] !== 1'b0 || ev[1][7:0] !== 8'd1) begin
      failures++; $display("FAIL basic_events n=%0d first=%h last=%h required make 1C/61 then break count 1", ev.size(),
                           ev.size() > 0 ? ev[0] : '0, ev.size() > 0 ? ev[ev.size()-1] : '0);
    end
  endtask

  task automatic test_shift();
    vec_t ev[$];
    do_reset();
    sq = '{8'h12, 8'h1C, 8'hF0, 8'h1C, 8'hF0, 8'h12};
    play(1);
    foreach (obs0[i]) begin
      checks += 2;
      if (obs0[i] !== exp0[i]) begin failures++; $display("FAIL shift dut0 cyc=%0d got=%h exp=%h", i, obs0[i], exp0[i]); end
      if (obs1[i] !== exp1[i]) begin failures++; $display("FAIL shift dut1 cyc=%0d got=%h exp=%h", i, obs1[i], exp1[i]); end
      if (obs0[i][29]) ev.push_back(obs0[i]);
    end
    checks++;
    if (ev.size() != 4 || ev[0][8] !== 1'b1 || ev[1][18:11] !== 8'h41 || sd0 !== 1'b0 || pc0 !== 8'd2) begin
      failures++; $display("FAIL shift_events n=%0d sd=%b count=%0d required 4 events, A, sd 0, count 2", ev.size(), sd0, pc0);
    end
  endtask

  task automatic test_repeat();
    int n0 = 0, n1 = 0;
    do_reset();
    sq = '{8'h1C, 8'h1C, 8'h1C, 8'hF0, 8'h1C};
    play(1);
    foreach (obs0[i]) begin
      checks += 2;
      if (obs0[i] !== exp0[i]) begin failures++; $display("FAIL repeat dut0 cyc=%0d got=%h exp=%h", i, obs0[i], exp0[i]); end
      if (obs1[i] !== exp1[i]) begin failures++; $display("FAIL repeat dut1 cyc=%0d got=%h exp=%h", i, obs1[i], exp1[i]); end
      n0 += int'(obs0[i][29]); n1 += int'(obs1[i][29]);
    end
    checks++;
    if (n0 != 2 || n1 != 4 || pc0 !== 8'd1 || pc1 !== 3'd1) begin
      failures++; $display("FAIL repeat_counts ev0=%0d ev1=%0d pc0=%0d pc1=%0d required 2 4 1 1", n0, n1, pc0, pc1);
    end
  endtask

  task automatic test_back_to_back();
    int run = 0, best = 0;
    vec_t ev[$];
    do_reset();
    sq = '{8'hE0, 8'h75, 8'hE0, 8'hF0, 8'h75};
    play(0);
    foreach (obs0[i]) begin
      checks += 2;
      if (obs0[i] !== exp0[i]) begin failures++; $display("FAIL b2b dut0 cyc=%0d got=%h exp=%h", i, obs0[i], exp0[i]); end
      if (obs1[i] !== exp1[i]) begin failures++; $display("FAIL b2b dut1 cyc=%0d got=%h exp=%h", i, obs1[i], exp1[i]); end
      run = obs0[i][30] ? 0 : run + 1;
      if (run > best) best = run;
      if (obs0[i][29]) ev.push_back(obs0[i]);
    end
    checks++;
    if (best != 5 || ev.size() != 2 || ev[0][28:20] !== 9'h0EB || ev[0][19] !== 1'b0 || ev[0][18:11] !== 8'h00
        || ev[1][20:19] !== 2'b11) begin
      failures++; $display("FAIL b2b_events pops=%0d n=%0d required 5 pops, ext make 75 then ext break", best, ev.size());
    end
  endtask

  task automatic test_proto_err();
    int np = 0;
    vec_t ev[$];
    do_reset();
    sq = '{8'hF0, 8'hE0, 8'h1C, 8'hAA, 8'hFA};
    play(1);
    foreach (obs0[i]) begin
      checks += 2;
      if (obs0[i] !== exp0[i]) begin failures++; $display("FAIL proto dut0 cyc=%0d got=%h exp=%h", i, obs0[i], exp0[i]); end
      if (obs1[i] !== exp1[i]) begin failures++; $display("FAIL proto dut1 cyc=%0d got=%h exp=%h", i, obs1[i], exp1[i]); end
      np += int'(obs0[i][10]);
      if (obs0[i][29]) ev.push_back(obs0[i]);
    end
    checks++;
    if (np != 1 || ev.size() != 1 || ev[0][28:19] !== {8'h1C, 2'b00}) begin
      failures++; $display("FAIL proto_events perr=%0d n=%0d required 1 pulse and one make 1C", np, ev.size());
    end
  endtask

  task automatic test_clr_mid();
    do_reset();
    sq = '{8'h1C, 8'hE0};
    play(0);
    clr = 1; ready = 1; data = 8'h33;
    #1;
    checks++;
    if (nd0 !== 1'b1) begin failures++; $display("FAIL clr_nextdata got=%b required=1", nd0); end
    @(posedge clk); @(negedge clk);
    checks++;
    if ({v0, c0, e0, b0, a0, kd0, sd0, pc0, pe0} !== 36'h0) begin
      failures++; $display("FAIL clr_outs got=%h required=0", {v0, c0, e0, b0, a0, kd0, sd0, pc0, pe0});
    end
    clr = 0; ready = 0;
    model_reset();
    sq = '{8'h1C};
    play(0);
    foreach (obs0[i]) begin
      checks += 2;
      if (obs0[i] !== exp0[i]) begin failures++; $display("FAIL clrmid dut0 cyc=%0d got=%h exp=%h", i, obs0[i], exp0[i]); end
      if (obs1[i] !== exp1[i]) begin failures++; $display("FAIL clrmid dut1 cyc=%0d got=%h exp=%h", i, obs1[i], exp1[i]); end
    end
    checks++;
    if (e0 !== 1'b0 || c0 !== 8'h1C || pc0 !== 8'd1 || a0 !== 8'h61) begin
      failures++; $display("FAIL clr_after ext=%b code=%h count=%0d ascii=%h required 0 1C 1 61", e0, c0, pc0, a0);
    end
  endtask

  task automatic test_wrap();
    do_reset();
    sq = '{8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B, 8'h34, 8'h33, 8'h43};
    play(0);
    foreach (obs0[i]) begin
      checks += 2;
      if (obs0[i] !== exp0[i]) begin failures++; $display("FAIL wrap dut0 cyc=%0d got=%h exp=%h", i, obs0[i], exp0[i]); end
      if (obs1[i] !== exp1[i]) begin failures++; $display("FAIL wrap dut1 cyc=%0d got=%h exp=%h", i, obs1[i], exp1[i]); end
    end
    checks++;
    if (pc0 !== 8'd9 || pc1 !== 3'd1) begin
      failures++; $display("FAIL wrap_count pc0=%0d pc1=%0d required 9 1", pc0, pc1);
    end
  endtask

  task automatic test_random();
    logic [7:0] pool[10] = '{8'h1C, 8'h32, 8'h29, 8'h5A, 8'h45, 8'h16, 8'h75, 8'h6B, 8'h1A, 8'h4D};
    logic [7:0] ign[6] = '{8'hAA, 8'hFA, 8'hFE, 8'h00, 8'hFF, 8'hE1};
    do_reset();
    sq.delete();
    for (int i = 0; i < 600; i++) begin
      case ($urandom_range(9, 0))
        0, 1:    sq.push_back(8'hE0);
        2, 3:    sq.push_back(8'hF0);
        4:       sq.push_back(ign[$urandom_range(5, 0)]);
        5:       sq.push_back($urandom_range(1, 0) ? 8'h12 : 8'h59);
        6:       sq.push_back(8'($urandom));
        default: sq.push_back(pool[$urandom_range(9, 0)]);
      endcase
    end
    play(2);
    foreach (obs0[i]) begin
      checks += 2;
      if (obs0[i] !== exp0[i]) begin failures++; $display("FAIL random dut0 cyc=%0d got=%h exp=%h", i, obs0[i], exp0[i]); end
      if (obs1[i] !== exp1[i]) begin failures++; $display("FAIL random dut1 cyc=%0d got=%h exp=%h", i, obs1[i], exp1[i]); end
    end
  endtask

  initial begin
    clr = 1; ready = 0; data = 8'h00;
    model_reset();
    @(negedge clk);
    test_reset();
    test_basic();
    test_shift();
    test_repeat();
    test_back_to_back();
    test_proto_err();
    test_clr_mid();
    test_wrap();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ps2_scan_decoder.md
Name: ps2_scan_decoder

Overview:
Consumes scan-code bytes from the PS/2 receive FIFO stage via its ready/data/nextdata_n handshake. Decodes Set-2 make/break/extended sequences into single key events with code, flags and ASCII. Tracks the held key, shift state and a press counter for the seven-segment/display logic downstream. Pure clk-domain block; no PS/2 line timing.

Parameters:
REPEAT_EN, 0, 1 = typematic repeats of the held key emit make events; 0 = suppressed.
CNT_W, 8, width of press counter.

Ports:
clk  in  1  system clock, all logic on rising edge.
clr  in  1  asynchronous active-high reset.
ready  in  1  upstream FIFO non-empty; data valid.
data  in  8  upstream FIFO head byte.
nextdata_n  out  1  active-low pop strobe to upstream.
key_valid  out  1  one-cycle event pulse.
key_code  out  8  scan code of event (prefixes stripped).
key_ext  out  1  event had E0 prefix.
key_break  out  1  event is a release.
key_ascii  out  8  ASCII of event; 0 if ext, break or unmapped.
key_down  out  1  a key is currently held (tracked key).
shift_down  out  1  left (12) or right (59) shift held.
press_count  out  CNT_W  count of non-repeat make events, wraps.
proto_err  out  1  one-cycle pulse on illegal prefix sequence.

Behaviour:
- Reset (clr=1, async): all registered outputs 0, FSM to S_BASE, held code/ext cleared; nextdata_n forced 1 while clr=1.
- Pop: nextdata_n = ~ready (combinational, clr low); every byte presented is consumed the same cycle. The upstream FIFO advances at that edge, so one byte/cycle is sustained; back-to-back bytes are legal.
- Byte latched at the pop edge; all event outputs are registered and appear exactly 1 cycle after the pop edge. key_valid/proto_err are high for exactly one cycle. key_code/ext/break/ascii hold their values until the next event.
- FSM (state advances on each consumed byte):
  S_BASE: E0->S_EXT; F0->S_BRK; AA,FA,FE,00,FF,E1 -> ignored, no event; other -> make(ext=0).
  S_EXT: F0->S_EXTBRK; E0 -> proto_err, stay S_EXT; other -> make(ext=1), ->S_BASE.
  S_BRK: E0 or F0 -> proto_err, ->S_BASE; other -> break(ext=0), ->S_BASE.
  S_EXTBRK: E0 or F0 -> proto_err, ->S_BASE; other -> break(ext=1), ->S_BASE.
- Make: if key_down and {ext,code} == held -> repeat: event only if REPEAT_EN=1, counter unchanged. Otherwise new press: event, press_count+1 (wraps from all-ones to 0), held={ext,code}, key_down=1.
- Break: always emits event (key_break=1, key_ascii=0). key_down cleared only if {ext,code} == held; else unchanged.
- Shift: non-ext make of 12/59 sets the corresponding shift bit; break clears it. shift_down = OR of both bits. Shift keys also produce normal events.
- ASCII: non-ext make only; letters lower-case, upper-case when shift_down as of the event (shift state before this byte); digits, space (29->20h), enter (5A->0Dh); all others 0.
- Reset mid-sequence (e.g. after E0) discards the prefix; first byte after reset is decoded in S_BASE.

Decomposition:
- Package ps2_pkg: byte constants PS2_EXT=E0, PS2_BRK=F0, ignore set {AA,FA,FE,00,FF,E1}, SC_LSHIFT=12, SC_RSHIFT=59; FSM state typedef {S_BASE,S_EXT,S_BRK,S_EXTBRK}.
- Sub-module ps2_ascii_rom: combinational lookup (code[7:0], shift) -> ascii[7:0].

Test Plan:
- Bytes 1C,F0,1C -> make code=1C ascii=61h key_down=1 press_count=1, then break code=1C key_down=0 ascii=0.
- 12,1C,F0,1C,F0,12 -> shift_down=1 after first byte; 1C make ascii=41h; shift_down=0 after final break; press_count=2.
- REPEAT_EN=0: 1C,1C,1C,F0,1C -> exactly one make and one break event, press_count=1. REPEAT_EN=1: three make events, press_count=1.
- E0,75,E0,F0,75 back-to-back (ready held, one byte/cycle) -> make ext=1 code=75 ascii=0, break ext=1; nextdata_n low 5 consecutive cycles.
- F0,E0,1C -> proto_err pulse, FSM to S_BASE, then make code=1C ext=0; AA,FA -> no events.
- Assert clr after E0 -> outputs 0; next 1C decodes as non-ext make with press_count=1.
